// File: rtl/cache_refill_responder.sv
// cache_refill_responder
//
// Memory-side responder for the data cache line-refill interface. It takes one
// line request at a time, either a read (miss refill) or a write (eviction
// write-back). The request is split into one word access per cycle on a
// fixed-latency backing memory. For a read, the returned words are assembled
// into a line. For a write, the latched line is sent out one word at a time.
// Each request ends with a one-cycle completion pulse.
//
// Ports:
//   clk, rstn             clock; synchronous active-low reset
//   req_valid/req_ready   request handshake; req_ready is registered and high only when idle
//   req_we                1 = line write, 0 = line read
//   req_addr              byte address; offset bits within the line are ignored
//   req_wline             write line; word i occupies bits [32i+31:32i]
//   resp_valid            one-cycle completion pulse
//   resp_rline            assembled read line; held until the next read overwrites it
//   mem_en/mem_we         backing memory access strobe / write enable
//   mem_addr              backing word address {line address, word index}
//   mem_wdata             backing memory write word
//   mem_rdata             backing memory read word, valid MEM_LATENCY cycles after its mem_en
//
// MEM_LATENCY must lie in 1..4.

module cache_refill_responder #(
  parameter int unsigned ADDR_LEN    = 25,
  parameter int unsigned DATA_LEN    = 32,
  parameter int unsigned LINE_SIZE   = 1024,
  parameter int unsigned OFFSET_LEN  = 7,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_LEN-1:0]  req_addr,
  input  logic [LINE_SIZE-1:0] req_wline,
  output logic                 resp_valid,
  output logic [LINE_SIZE-1:0] resp_rline,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_LEN-3:0]  mem_addr,
  output logic [DATA_LEN-1:0]  mem_wdata,
  input  logic [DATA_LEN-1:0]  mem_rdata
);

  localparam int unsigned WORDS         = LINE_SIZE / DATA_LEN;
  localparam int unsigned IDX_LEN       = $clog2(WORDS);
  localparam int unsigned LINE_ADDR_LEN = ADDR_LEN - OFFSET_LEN;
  localparam logic [IDX_LEN-1:0] LAST_IDX = IDX_LEN'(WORDS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRdIssue,
    StRdDrain,
    StWrIssue,
    StResp
  } state_e;

  state_e                         state_q, state_d;
  logic [IDX_LEN-1:0]             word_idx_q, word_idx_d;
  logic [IDX_LEN-1:0]             cap_cnt_q, cap_cnt_d;
  logic [MEM_LATENCY-1:0]         rd_vld_q, rd_vld_d;
  logic [LINE_ADDR_LEN-1:0]       line_addr_q;
  logic [WORDS-1:0][DATA_LEN-1:0] wline_q;
  logic [WORDS-1:0][DATA_LEN-1:0] rline_q;
  logic                           req_ready_q;

  logic accept;
  logic rd_issue;
  logic rd_return;

  // The offset bits only select a byte inside the line, so they are not used.
  logic unused_offset;
  assign unused_offset = ^req_addr[OFFSET_LEN-1:0];

  assign accept    = req_valid & req_ready_q;
  assign rd_issue  = (state_q == StRdIssue);
  assign rd_return = rd_vld_q[MEM_LATENCY-1];

  // Next-state logic and the memory and response strobes.
  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = req_we ? StWrIssue : StRdIssue;
          word_idx_d = '0;
        end
      end
      StRdIssue: begin
        mem_en     = 1'b1;
        word_idx_d = word_idx_q + 1'b1;
        if (word_idx_q == LAST_IDX) begin
          state_d    = StRdDrain;
          word_idx_d = '0;
        end
      end
      StRdDrain: begin
        // The last return always arrives here, because MEM_LATENCY is at least 1.
        if (rd_return && (cap_cnt_q == LAST_IDX)) begin
          state_d = StResp;
        end
      end
      StWrIssue: begin
        mem_en     = 1'b1;
        mem_we     = 1'b1;
        word_idx_d = word_idx_q + 1'b1;
        if (word_idx_q == LAST_IDX) begin
          state_d    = StResp;
          word_idx_d = '0;
        end
      end
      StResp: begin
        resp_valid = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Return tracking: a valid bit follows each read through a pipe that matches
  // the memory latency. The capture counter then selects the destination word.
  always_comb begin
    rd_vld_d    = '0;
    rd_vld_d[0] = rd_issue;
    for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
      rd_vld_d[i] = rd_vld_q[i-1];
    end
  end

  always_comb begin
    cap_cnt_d = cap_cnt_q;
    if (accept) begin
      cap_cnt_d = '0;
    end else if (rd_return) begin
      cap_cnt_d = cap_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      word_idx_q  <= '0;
      cap_cnt_q   <= '0;
      rd_vld_q    <= '0;
      line_addr_q <= '0;
      wline_q     <= '0;
      rline_q     <= '0;
      req_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      cap_cnt_q  <= cap_cnt_d;
      rd_vld_q   <= rd_vld_d;
      // req_ready is registered: it goes high in the first cycle spent in idle.
      req_ready_q <= (state_d == StIdle);
      if (accept) begin
        line_addr_q <= req_addr[ADDR_LEN-1:OFFSET_LEN];
        wline_q     <= req_wline;
      end
      if (rd_return) begin
        rline_q[cap_cnt_q] <= mem_rdata;
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_rline = rline_q;
  assign mem_addr   = {line_addr_q, word_idx_q};
  assign mem_wdata  = (state_q == StWrIssue) ? wline_q[word_idx_q] : '0;

endmodule

// File: tb/tb_cache_refill_responder.sv
// Bench for cache_refill_responder. Three lanes run MEM_LATENCY 2, 1 and 4,
// and each lane has its own backing memory model. Lane 0 is checked for every
// memory access and every response. Lanes 1 and 2 are checked for responses.
module tb_cache_refill_responder;

  typedef struct {
    int          cyc;
    logic [22:0] addr;
    logic        we;
    logic [31:0] data;
  } mem_exp_t;

  typedef struct {
    int            inst;
    int            cyc;
    logic          rd;
    logic [1023:0] line;
  } resp_exp_t;

  logic                 clk;
  logic                 rstn;
  logic [2:0]           req_valid_w;
  logic [2:0]           req_ready_w;
  logic                 req_we;
  logic [24:0]          req_addr;
  logic [1023:0]        req_wline;
  logic [2:0]           resp_valid_w;
  logic [2:0][1023:0]   resp_rline_w;
  logic [2:0]           mem_en_w;
  logic [2:0]           mem_we_w;
  logic [2:0][22:0]     mem_addr_w;
  logic [2:0][31:0]     mem_wdata_w;
  logic [2:0][31:0]     mem_rdata_w;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  mem_exp_t  exp_mem_q[$];
  resp_exp_t exp_resp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

    logic [63:0] wr_flag = '0;
    logic [31:0] wr_data [64];
    logic [31:0] pipe [LAT];
    logic [5:0]  idx;
    logic [31:0] rd_word;

    // Only two lines are used: 0x20..0x3F and 0x7FFFE0..0x7FFFFF.
    assign idx     = {mem_addr_w[g][22], mem_addr_w[g][4:0]};
    assign rd_word = wr_flag[idx] ? wr_data[idx] : (32'hA5000000 + {9'd0, mem_addr_w[g]});

    always @(posedge clk) begin
      if (mem_en_w[g] && mem_we_w[g]) begin
        wr_flag[idx] <= 1'b1;
        wr_data[idx] <= mem_wdata_w[g];
      end
      pipe[0] <= (mem_en_w[g] && !mem_we_w[g]) ? rd_word : 32'hDEADBEEF;
      for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
    end
    assign mem_rdata_w[g] = pipe[LAT-1];

    cache_refill_responder #(
      .ADDR_LEN   (25),
      .DATA_LEN   (32),
      .LINE_SIZE  (1024),
      .OFFSET_LEN (7),
      .MEM_LATENCY(LAT)
    ) u_dut (
      .clk       (clk),
      .rstn      (rstn),
      .req_valid (req_valid_w[g]),
      .req_ready (req_ready_w[g]),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wline (req_wline),
      .resp_valid(resp_valid_w[g]),
      .resp_rline(resp_rline_w[g]),
      .mem_en    (mem_en_w[g]),
      .mem_we    (mem_we_w[g]),
      .mem_addr  (mem_addr_w[g]),
      .mem_wdata (mem_wdata_w[g]),
      .mem_rdata (mem_rdata_w[g])
    );
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_line(input string tag, input logic [1023:0] obs, input logic [1023:0] expv);
    int w;
    w = 0;
    total++;
    assert (obs === expv) else begin
      bad++;
      for (int k = 31; k >= 0; k--) if (obs[32*k +: 32] !== expv[32*k +: 32]) w = k;
      $error("FAIL %s: word %0d observed=0x%08h expected=0x%08h",
             tag, w, obs[32*w +: 32], expv[32*w +: 32]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_read(input int inst, input int acc, input logic [17:0] la,
                           input logic [1023:0] line);
    mem_exp_t  me;
    resp_exp_t re;
    if (inst == 0) begin
      for (int i = 0; i < 32; i++) begin
        me.cyc  = acc + 1 + i;
        me.addr = {la, 5'(i)};
        me.we   = 1'b0;
        me.data = '0;
        exp_mem_q.push_back(me);
      end
    end
    re.inst = inst;
    re.cyc  = acc + 33 + lat_of(inst);
    re.rd   = 1'b1;
    re.line = line;
    exp_resp_q.push_back(re);
  endtask

  task automatic push_write(input int acc, input logic [17:0] la, input logic [1023:0] line);
    mem_exp_t  me;
    resp_exp_t re;
    for (int i = 0; i < 32; i++) begin
      me.cyc  = acc + 1 + i;
      me.addr = {la, 5'(i)};
      me.we   = 1'b1;
      me.data = line[32*i +: 32];
      exp_mem_q.push_back(me);
    end
    re.inst = 0;
    re.cyc  = acc + 33;
    re.rd   = 1'b0;
    re.line = '0;
    exp_resp_q.push_back(re);
  endtask

  // Drive a request and leave req_valid high. acc is the cycle in which it was accepted.
  task automatic do_req(input logic [2:0] mask, input logic we, input logic [24:0] addr,
                        input logic [1023:0] wline, output int acc);
    int n;
    n = 0;
    req_valid_w = mask;
    req_we      = we;
    req_addr    = addr;
    req_wline   = wline;
    acc         = -1;
    while (acc < 0 && n < 200) begin
      if ((req_ready_w & mask) == mask) acc = cyc;
      else begin
        tick();
        n++;
      end
    end
    chk("accept_in_time", {63'd0, acc >= 0}, 64'd1);
  endtask

  task automatic read_req(input logic [2:0] mask, input logic [24:0] addr,
                          input logic [1023:0] line, output int acc);
    do_req(mask, 1'b0, addr, '0, acc);
    for (int i = 0; i < 3; i++) if (mask[i]) push_read(i, acc, addr[24:7], line);
    tick();
    req_valid_w = '0;
  endtask

  task automatic write_req(input logic [24:0] addr, input logic [1023:0] line, output int acc);
    do_req(3'b001, 1'b1, addr, line, acc);
    push_write(acc, addr[24:7], line);
    tick();
    req_valid_w = '0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((exp_mem_q.size() != 0 || exp_resp_q.size() != 0) && n < bound) begin
      tick();
      n++;
    end
    chk("drain_in_time", 64'(exp_mem_q.size() + exp_resp_q.size()), 64'd0);
    exp_mem_q.delete();
    exp_resp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready_w[0]), 64'd0);
    chk({tag, "_resp_valid"}, 64'(resp_valid_w[0]), 64'd0);
    chk_line({tag, "_resp_rline"}, resp_rline_w[0], '0);
    chk({tag, "_mem_en"}, 64'(mem_en_w[0]), 64'd0);
    chk({tag, "_mem_we"}, 64'(mem_we_w[0]), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr_w[0]), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata_w[0]), 64'd0);
  endtask

  // Scoreboard consumer: compare DUT activity against the queued expectations.
  mem_exp_t  mon_me;
  int        mon_hit;
  always @(negedge clk) begin
    if (mem_en_w[0] === 1'b1) begin
      if (exp_mem_q.size() == 0) chk("mem_en_unexpected", 64'(mem_en_w[0]), 64'd0);
      else begin
        mon_me = exp_mem_q.pop_front();
        chk("mem_cycle", 64'(cyc), 64'(mon_me.cyc));
        chk("mem_addr", 64'(mem_addr_w[0]), 64'(mon_me.addr));
        chk("mem_we", 64'(mem_we_w[0]), 64'(mon_me.we));
        if (mon_me.we) chk("mem_wdata", 64'(mem_wdata_w[0]), 64'(mon_me.data));
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (resp_valid_w[i] === 1'b1) begin
        mon_hit = -1;
        for (int k = exp_resp_q.size() - 1; k >= 0; k--) if (exp_resp_q[k].inst == i) mon_hit = k;
        if (mon_hit < 0) chk("resp_unexpected", 64'(resp_valid_w[i]), 64'd0);
        else begin
          chk("resp_cycle", 64'(cyc), 64'(exp_resp_q[mon_hit].cyc));
          if (exp_resp_q[mon_hit].rd) chk_line("resp_rline", resp_rline_w[i], exp_resp_q[mon_hit].line);
          exp_resp_q.delete(mon_hit);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            acc;
    int            acc2;
    int            pulses;
    logic [1023:0] line80;
    logic [1023:0] wb_line;

    rstn        = 1'b0;
    req_valid_w = '0;
    req_we      = 1'b0;
    req_addr    = '0;
    req_wline   = '0;
    for (int w = 0; w < 32; w++) begin
      line80[32*w +: 32]  = 32'hA5000020 + 32'(w);
      wb_line[32*w +: 32] = 32'h00001000 + 32'(w);
    end

    // Reset values, then ready from the first edge with rstn high.
    tick();
    chk_reset_outputs("reset");
    rstn = 1'b1;
    tick();
    chk("ready_after_reset", 64'(req_ready_w), 64'd7);

    // Read refill on all three latencies at once (resp in cycles 35, 34 and 37).
    read_req(3'b111, 25'h0000080, line80, acc);
    wait_idle(120);

    // Write-back to the top line, then read the same line back.
    write_req(25'h1FFFF80, wb_line, acc);
    wait_idle(80);
    chk_line("rline_held_after_write", resp_rline_w[0], line80);
    read_req(3'b001, 25'h1FFFF80, wb_line, acc);
    wait_idle(80);

    // Unaligned address: the low 7 bits are ignored.
    read_req(3'b001, 25'h00000FF, line80, acc);
    wait_idle(80);

    // req_valid held across two requests: the second request is accepted at cycle acc+36.
    do_req(3'b001, 1'b0, 25'h0000080, '0, acc);
    push_read(0, acc, 18'h00001, line80);
    tick();
    do_req(3'b001, 1'b0, 25'h1FFFF80, '0, acc2);
    chk("busy_accept_cycle", 64'(acc2), 64'(acc + 36));
    push_read(0, acc + 36, 18'h3FFFF, wb_line);
    tick();
    req_valid_w = '0;
    wait_idle(150);

    // Reset during a read in cycle 10: abort, with no response and no stale data.
    read_req(3'b001, 25'h0000080, line80, acc);
    while (cyc < acc + 10) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    exp_mem_q.delete();
    exp_resp_q.delete();
    chk_reset_outputs("midreset");
    tick();
    chk("ready_after_midreset", 64'(req_ready_w[0]), 64'd1);
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      if (resp_valid_w[0] === 1'b1) pulses++;
      tick();
    end
    chk("no_resp_after_reset", 64'(pulses), 64'd0);
    read_req(3'b001, 25'h0000080, line80, acc);
    wait_idle(80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
